pulse_request_arbiter: RTL and testbench
========================================

Name: pulse_request_arbiter

Overview:
- Shares one accelerator engine among NUM_REQ level-signalling requesters, for example a host control bit, a debug push-button, or a test sequencer.
- Each request input is edge-detected internally on its rising edge. Edges are latched as pending requests.
- Pending requests are granted round-robin: one single-cycle start pulse plus a select index is issued to the engine, then the arbiter waits for the engine's done.
- On completion it returns a one-cycle acknowledge pulse to the granted requester. A hung engine is recovered by a watchdog.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDX_W, 2, width of the grant index; must equal ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; 0 disables the watchdog.
- CNT_W, 16, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_level  input  NUM_REQ  per-requester level request; a rising edge equals one request.
- eng_start  output  1  one-cycle start pulse to the shared engine.
- eng_sel  output  IDX_W  index of the granted requester; stable from ISSUE through ACK.
- eng_done  input  1  engine completion, single-cycle or level; sampled only in WAIT.
- req_ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- req_pending  output  NUM_REQ  latched, not-yet-granted requests.
- busy  output  1  high whenever state is not IDLE.
- timeout_err  output  1  one-cycle pulse when the watchdog expires.

Behaviour:
Reset values (reset is synchronous, active-high; clock is clk):
- All outputs are 0.
- req_prev = 0, pending = 0, state = IDLE, wd_cnt = 0.
- last_grant = NUM_REQ-1, so channel 0 has first priority.
- Reset asserted in any state aborts the operation the next edge. No ack or err is issued for the aborted operation.
- A level held high through reset is seen as a fresh rise on the first cycle after reset deasserts.

Edge detection:
- rise[i] = req_level[i] & ~req_prev[i].
- req_prev <= req_level every non-reset edge.
- On rise[i], pending[i] is set at that edge.
- A rise while pending[i] is already set is merged and dropped. Holding the level high never re-requests.

Same-edge set and clear:
- If rise[i] and the grant of channel i occur on the same edge, the set wins. pending[i] stays 1 as a new request.

Grant selection:
- Round-robin search of pending starting at (last_grant+1) mod NUM_REQ, wrapping.
- The first set bit wins.

FSM (registered outputs):
- IDLE:
  - If pending != 0 at an edge: load eng_sel with the winner, clear its pending bit, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - eng_start = 1 for exactly this one cycle.
  - wd_cnt <= 0. Next state is WAIT.
  - eng_done is ignored in this state.
- WAIT:
  - eng_done = 1 sampled: go to ACK with the success flag set.
  - Otherwise wd_cnt increments. If TIMEOUT_CYCLES != 0 and wd_cnt == TIMEOUT_CYCLES-1, go to ACK with the error flag set.
  - If done and timeout occur on the same edge, done wins.
- ACK:
  - On success: req_ack[eng_sel] = 1. On error: timeout_err = 1 and req_ack stays 0.
  - last_grant <= eng_sel. Next state is IDLE.
  - eng_sel returns to 0 in IDLE.

Latency:
- Rise sampled at edge k: pending is visible after edge k, and eng_start is high between edges k+1 and k+2. Request-to-start is 2 cycles.
- Done sampled at edge m: req_ack is high between edges m and m+1.
- Back-to-back operations have a minimum 2-cycle gap from ack to the next start.

Other rules:
- eng_done outside WAIT has no effect.
- Exactly one operation is outstanding at a time.
- req_ack and timeout_err are never both high in the same cycle.

Test Plan:
- Single request: reset, then raise req_level[1] and hold it for 20 cycles. Engine returns done 5 cycles after start. Required: eng_start exactly 2 cycles after the rise with eng_sel=1, req_ack=4'b0010 for 1 cycle, and no second start while the level stays high.
- Simultaneous requests: rise req_level[0] and req_level[2] on the same cycle. Required: grant order 0 then 2; req_pending=4'b0101, then 4'b0100, then 0.
- Round-robin fairness: after a grant to 2, rises on 0, 1 and 3 while busy. Required: grant order 3, 0, 1; all three remain pending while busy and are not lost.
- Watchdog: TIMEOUT_CYCLES=8, grant channel 3 and never assert done. Required: timeout_err pulse exactly 8 cycles after the WAIT entry, req_ack stays 0, and the next pending request is then granted.
- Same-edge set and clear: rise on channel 0 on the same edge channel 0 is granted. Required: pending[0] stays 1 and channel 0 is granted a second time after the first ack.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT. Required: all outputs 0 the next cycle, pending cleared, no ack or err, and channel 0 has first priority afterwards.

Source files
------------

// File: rtl/pulse_request_arbiter.sv
// pulse_request_arbiter
//   Shares one engine among NUM_REQ level-signalling requesters. Each rising
//   edge on req_level latches a pending request. Pending requests are granted
//   round-robin. A grant issues one start pulse with a select index, then waits
//   for eng_done. Completion returns a one-cycle ack to the granted requester.
//   A watchdog in WAIT recovers from a hung engine and reports timeout_err.
//
// Handshake: eng_start is a single-cycle pulse with eng_sel valid. eng_sel
//   holds from ISSUE through ACK. eng_done is only looked at in WAIT and may be
//   a pulse or a level. req_ack and timeout_err are single-cycle, exclusive
//   pulses, and one operation is outstanding at a time.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   req_level    per-requester level request (rising edge = one request)
//   eng_start    one-cycle start pulse to the engine
//   eng_sel      granted requester index
//   eng_done     engine completion
//   req_ack      one-hot completion pulse
//   req_pending  latched, not-yet-granted requests
//   busy         state != IDLE
//   timeout_err  one-cycle pulse on watchdog expiry
module pulse_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_level,
  output logic               eng_start,
  output logic [IDX_W-1:0]   eng_sel,
  input  logic               eng_done,
  output logic [NUM_REQ-1:0] req_ack,
  output logic [NUM_REQ-1:0] req_pending,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_CH  = IDX_W'(NUM_REQ - 1);

  state_t             state, state_n;
  logic [NUM_REQ-1:0] req_prev;
  logic [NUM_REQ-1:0] pending, pending_n;
  logic [IDX_W-1:0]   last_grant, last_grant_n;
  logic [IDX_W-1:0]   sel_q, sel_n;
  logic [CNT_W-1:0]   wd_cnt, wd_cnt_n;
  logic               ok_flag, ok_flag_n;

  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] grant_clr;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   win_hi, win_lo;
  logic               any_hi;

  assign rise = req_level & ~req_prev;

  // Round-robin pick: the lowest pending channel above last_grant, or, if there
  // is none, the lowest pending channel overall (wrap-around). The descending
  // scan leaves the lowest match in each candidate.
  always_comb begin
    any_hi = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_lo = IDX_W'(i);
        if (i > int'(last_grant)) begin
          any_hi = 1'b1;
          win_hi = IDX_W'(i);
        end
      end
    end
    winner = any_hi ? win_hi : win_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_prev   <= '0;
      pending    <= '0;
      last_grant <= LAST_CH;
      sel_q      <= '0;
      wd_cnt     <= '0;
      ok_flag    <= 1'b0;
    end else begin
      state      <= state_n;
      req_prev   <= req_level;
      pending    <= pending_n;
      last_grant <= last_grant_n;
      sel_q      <= sel_n;
      wd_cnt     <= wd_cnt_n;
      ok_flag    <= ok_flag_n;
    end
  end

  always_comb begin
    state_n      = state;
    sel_n        = sel_q;
    last_grant_n = last_grant;
    wd_cnt_n     = wd_cnt;
    ok_flag_n    = ok_flag;
    grant_clr    = '0;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          sel_n     = winner;
          grant_clr = ONE_HOT0 << winner;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_cnt_n = '0;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over a watchdog expiry on the same edge.
        if (eng_done) begin
          ok_flag_n = 1'b1;
          state_n   = S_ACK;
        end else begin
          wd_cnt_n = wd_cnt + CNT_W'(1);
          if ((TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST)) begin
            ok_flag_n = 1'b0;
            state_n   = S_ACK;
          end
        end
      end
      S_ACK: begin
        last_grant_n = sel_q;
        sel_n        = '0;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // A new rise on the channel being granted this edge survives as a fresh
    // request.
    pending_n = (pending & ~grant_clr) | rise;
  end

  assign eng_start   = (state == S_ISSUE);
  assign eng_sel     = sel_q;
  assign busy        = (state != S_IDLE);
  assign req_pending = pending;
  assign req_ack     = ((state == S_ACK) && ok_flag) ? (ONE_HOT0 << sel_q) : '0;
  assign timeout_err = (state == S_ACK) && !ok_flag;

endmodule

// File: tb/tb_pulse_request_arbiter.sv
// tb_pulse_request_arbiter
//   Bench for pulse_request_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8). A cycle
//   table covers the single-request timeline. Hand-written sequences cover
//   simultaneous requests, fairness, the watchdog, same-edge set/clear and
//   reset during WAIT. Expected grants and completions are queued up front.
//   They are popped as the DUT starts and completes operations.
module tb_pulse_request_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_level = '0;
  logic       eng_done = 1'b0;
  logic       eng_start;
  logic [1:0] eng_sel;
  logic [3:0] req_ack;
  logic [3:0] req_pending;
  logic       busy;
  logic       timeout_err;

  pulse_request_arbiter #(
    .NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYCLES(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .req_level(req_level),
    .eng_start(eng_start), .eng_sel(eng_sel), .eng_done(eng_done),
    .req_ack(req_ack), .req_pending(req_pending), .busy(busy),
    .timeout_err(timeout_err)
  );

  // clock / global limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // scoreboard: {timeout_err, req_ack} completions and expected grant indices
  logic [4:0] exp_q[$];
  logic [1:0] exp_sel_q[$];

  bit eng_auto = 1'b0;
  int eng_cnt  = 0;

  typedef struct {
    logic [3:0] req;
    logic       start;
    logic [1:0] sel;
    logic [3:0] ack;
    logic [3:0] pend;
    logic       busy;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, score them, then
  // step the engine model (done is sampled 5 edges after the start edge).
  task automatic tick();
    @(posedge clk);
    #1;
    if (eng_start) begin
      if (exp_sel_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start actual=sel %0d required=no start", eng_sel);
      end else begin
        check("grant_sel", {30'b0, eng_sel}, {30'b0, exp_sel_q.pop_front()});
      end
    end
    if ((req_ack != 4'b0) || timeout_err) begin
      check("ack_err_exclusive", {31'b0, (req_ack != 4'b0) && timeout_err}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion actual=%0h required=none", {timeout_err, req_ack});
      end else begin
        check("completion", {27'b0, timeout_err, req_ack}, {27'b0, exp_q.pop_front()});
      end
    end
    if (eng_done) eng_done = 1'b0;
    if (eng_start && eng_auto) begin
      eng_cnt = 4;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
  endtask

  task automatic do_reset(input logic [3:0] lvl);
    eng_cnt   = 0;
    eng_done  = 1'b0;
    reset     = 1'b1;
    req_level = lvl;
    tick();
    check("reset_outputs", {20'b0, eng_start, eng_sel, req_ack, req_pending, busy, timeout_err}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || (req_pending != 4'b0) || (exp_q.size() != 0) || (exp_sel_q.size() != 0)) && (n < budget)) begin
      tick();
      n++;
    end
    check("drain_timeout", {31'b0, n >= budget}, 32'd0);
    check("queues_empty", exp_q.size() + exp_sel_q.size(), 32'd0);
  endtask

  task automatic wait_ack(input logic [3:0] target, input int budget);
    int n = 0;
    while ((req_ack !== target) && (n < budget)) begin
      tick();
      n++;
    end
    check("wait_ack_timeout", {31'b0, n >= budget}, 32'd0);
  endtask

  initial begin
    // single-request timeline, one row per cycle
    for (int i = 0; i < 20; i++) vecs[i] = '{4'b0010, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    vecs[0].pend  = 4'b0010;
    vecs[1].start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      vecs[i].sel  = 2'd1;
      vecs[i].busy = 1'b1;
    end
    vecs[6].ack = 4'b0010;

    // ---- single request, level held 20 cycles ----
    do_reset(4'b0000);
    eng_auto = 1'b1;
    exp_sel_q.push_back(2'd1);
    exp_q.push_back(5'b0_0010);
    for (int i = 0; i < 20; i++) begin
      req_level = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i),
            {20'b0, eng_start, eng_sel, req_ack, req_pending, busy},
            {20'b0, vecs[i].start, vecs[i].sel, vecs[i].ack, vecs[i].pend, vecs[i].busy});
    end
    req_level = 4'b0000;
    drain(50);

    // ---- simultaneous requests on 0 and 2 ----
    do_reset(4'b0000);
    exp_sel_q.push_back(2'd0);
    exp_sel_q.push_back(2'd2);
    exp_q.push_back(5'b0_0001);
    exp_q.push_back(5'b0_0100);
    req_level = 4'b0101;
    tick();
    check("sim_pend_both", {28'b0, req_pending}, 32'h5);
    tick();
    check("sim_pend_after_first", {28'b0, req_pending}, 32'h4);
    repeat (6) tick();
    check("sim_pend_hold", {28'b0, req_pending}, 32'h4);
    tick();
    check("sim_second_start", {29'b0, eng_start, eng_sel}, {29'b0, 1'b1, 2'd2});
    check("sim_pend_empty", {28'b0, req_pending}, 32'h0);
    req_level = 4'b0000;
    drain(100);

    // ---- round-robin fairness after a grant to 2 ----
    do_reset(4'b0000);
    exp_sel_q.push_back(2'd2);
    exp_sel_q.push_back(2'd3);
    exp_sel_q.push_back(2'd0);
    exp_sel_q.push_back(2'd1);
    exp_q.push_back(5'b0_0100);
    exp_q.push_back(5'b0_1000);
    exp_q.push_back(5'b0_0001);
    exp_q.push_back(5'b0_0010);
    req_level = 4'b0100;
    repeat (4) tick();
    req_level = 4'b1111;
    tick();
    check("rr_pend_while_busy", {27'b0, busy, req_pending}, {27'b0, 1'b1, 4'b1011});
    req_level = 4'b0000;
    drain(200);

    // ---- watchdog: channel 3 never completes ----
    do_reset(4'b0000);
    eng_auto = 1'b0;
    exp_sel_q.push_back(2'd3);
    exp_q.push_back(5'b1_0000);
    req_level = 4'b1000;
    tick();
    tick();
    req_level = 4'b1010;
    tick();
    check("wd_pend_next", {28'b0, req_pending}, 32'h2);
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("wd_early%0d", k), {31'b0, timeout_err}, 32'd0);
    end
    tick();
    check("wd_expire", {27'b0, timeout_err, req_ack}, {27'b0, 5'b1_0000});
    eng_auto = 1'b1;
    exp_sel_q.push_back(2'd1);
    exp_q.push_back(5'b0_0010);
    req_level = 4'b0000;
    drain(100);

    // ---- same-edge set and clear on channel 0 ----
    do_reset(4'b0000);
    eng_auto = 1'b1;
    exp_sel_q.push_back(2'd1);
    exp_sel_q.push_back(2'd0);
    exp_sel_q.push_back(2'd0);
    exp_q.push_back(5'b0_0010);
    exp_q.push_back(5'b0_0001);
    exp_q.push_back(5'b0_0001);
    req_level = 4'b0010;
    tick();
    tick();
    req_level = 4'b0011;
    tick();
    req_level = 4'b0010;
    tick();
    wait_ack(4'b0010, 20);
    tick();
    check("sse_idle_pend", {27'b0, busy, req_pending}, {27'b0, 1'b0, 4'b0001});
    req_level = 4'b0011;
    tick();
    check("sse_grant_and_keep", {25'b0, eng_start, eng_sel, req_pending},
          {25'b0, 1'b1, 2'd0, 4'b0001});
    req_level = 4'b0000;
    drain(100);

    // ---- reset during WAIT ----
    do_reset(4'b0000);
    eng_auto = 1'b0;
    exp_sel_q.push_back(2'd2);
    req_level = 4'b0100;
    repeat (4) tick();
    check("mid_wait_busy", {31'b0, busy}, 32'd1);
    do_reset(4'b0100);
    eng_auto = 1'b1;
    exp_sel_q.push_back(2'd0);
    exp_sel_q.push_back(2'd2);
    exp_sel_q.push_back(2'd3);
    exp_q.push_back(5'b0_0001);
    exp_q.push_back(5'b0_0100);
    exp_q.push_back(5'b0_1000);
    req_level = 4'b1101;
    tick();
    check("post_reset_rise", {28'b0, req_pending}, 32'hd);
    req_level = 4'b0000;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
